// File: rtl/smi_master_if.sv
// MDIO management master command/response and pad-side signals.
// The master modport is the PHY-management block's view; slave is the requesting client.
interface smi_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;

    modport master (
        input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata, mdio_i,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, mdc, mdio_o, mdio_oe
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata, mdio_i,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, mdc, mdio_o, mdio_oe
    );
endinterface

// File: rtl/smi_master.sv
// Clause-22 MDIO master: 64-bit frame plus one idle bit, accept-to-rsp_valid = 130*CLK_DIV clk.
// Backpressure: cmd_ready only in IDLE with the PHY out of reset; phy_reset aborts with no response.
module smi_master #(
    parameter int CLK_DIV = 10
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       phy_reset,
    smi_master_if.master bus
);
    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_END} state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic             mdc_q;
    logic [4:0]       cnt_q;
    logic [62:0]      tx_q;
    logic             wr_q;
    logic [15:0]      rd_sh_q;
    logic             ta_q;
    logic             mdio_o_q;
    logic             mdio_oe_q;
    logic             busy_q;
    logic             rsp_valid_q;
    logic [15:0]      rsp_rdata_q;
    logic             rsp_err_q;
    logic             run_q;
    logic             sync1_q;
    logic             sync2_q;

    logic        div_wrap;
    logic        bit_end;
    logic        accept;
    logic [62:0] frame;

    assign div_wrap = (div_q == DIV_W'(CLK_DIV - 1));
    assign bit_end  = div_wrap & mdc_q;
    assign bus.cmd_ready = (state_q == S_IDLE) & ~phy_reset & run_q;
    assign accept   = bus.cmd_valid & bus.cmd_ready;

    // Leading preamble bit is implicit: it is loaded straight into mdio_o on accept.
    assign frame = {31'h7FFF_FFFF, 2'b01, (bus.cmd_write ? 2'b01 : 2'b10),
                    bus.cmd_phy_addr, bus.cmd_reg_addr,
                    (bus.cmd_write ? 2'b10 : 2'b11),
                    (bus.cmd_write ? bus.cmd_wdata : 16'hFFFF)};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.mdio_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            mdc_q       <= 1'b0;
            cnt_q       <= '0;
            tx_q        <= '1;
            wr_q        <= 1'b0;
            rd_sh_q     <= '0;
            ta_q        <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            if (phy_reset && state_q != S_IDLE) begin
                state_q   <= S_IDLE;
                div_q     <= '0;
                mdc_q     <= 1'b0;
                mdio_oe_q <= 1'b0;
                mdio_o_q  <= 1'b1;
                busy_q    <= 1'b0;
            end else if (state_q == S_IDLE) begin
                div_q <= '0;
                mdc_q <= 1'b0;
                if (accept) begin
                    state_q   <= S_PRE;
                    cnt_q     <= '0;
                    busy_q    <= 1'b1;
                    wr_q      <= bus.cmd_write;
                    tx_q      <= frame;
                    mdio_o_q  <= 1'b1;
                    mdio_oe_q <= 1'b1;
                end
            end else begin
                div_q <= div_wrap ? '0 : div_q + DIV_W'(1);
                if (div_wrap) mdc_q <= ~mdc_q;
                // Bit boundary: last clk of the high half, where the input is sampled too.
                if (bit_end) begin
                    tx_q     <= {tx_q[61:0], 1'b1};
                    mdio_o_q <= tx_q[62];
                    cnt_q    <= cnt_q + 5'd1;
                    case (state_q)
                        S_PRE: if (cnt_q == 5'd31) begin
                            state_q <= S_HDR;
                            cnt_q   <= '0;
                        end
                        S_HDR: if (cnt_q == 5'd13) begin
                            state_q   <= S_TA;
                            cnt_q     <= '0;
                            mdio_oe_q <= wr_q;
                        end
                        S_TA: if (cnt_q == 5'd1) begin
                            ta_q    <= sync2_q;
                            state_q <= S_DATA;
                            cnt_q   <= '0;
                        end
                        S_DATA: begin
                            rd_sh_q <= {rd_sh_q[14:0], sync2_q};
                            if (cnt_q == 5'd15) begin
                                state_q   <= S_END;
                                cnt_q     <= '0;
                                mdio_oe_q <= 1'b0;
                                mdio_o_q  <= 1'b1;
                            end
                        end
                        S_END: begin
                            state_q     <= S_IDLE;
                            mdio_o_q    <= 1'b1;
                            busy_q      <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            if (!wr_q) begin
                                rsp_rdata_q <= rd_sh_q;
                                rsp_err_q   <= ta_q;
                            end
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.mdc       = mdc_q;
    assign bus.mdio_o    = mdio_o_q;
    assign bus.mdio_oe   = mdio_oe_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
